dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares one data-memory port between num_cores_p cores using the existing two-phase valid/yumi protocol: request valid/yumi, then response valid/yumi.
- Grants are round-robin. One transaction is outstanding at a time, and each grant is held from request through response completion.
- Sits between the cores' to_mem_o/from_mem_i/data_mem_addr ports and the single data memory.
- Raises a sticky timeout flag when memory stalls past a programmable bound.

Parameters:
- num_cores_p, 4, number of requesting cores (min 2).
- addr_width_p, 32, data memory address width.
- timeout_p, 255, cycles a granted transaction may stay in REQ+RESP before timeout_o sets.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- core_req_i  in  num_cores_p x mem_in_s  per-core request (write_data, valid, wen, byte_not_word, yumi)
- core_addr_i  in  num_cores_p x addr_width_p  per-core data_mem_addr
- core_resp_o  out  num_cores_p x mem_out_s  per-core response (read_data, valid, yumi)
- mem_req_o  out  mem_in_s  request to data memory
- mem_addr_o  out  addr_width_p  address to data memory
- mem_resp_i  in  mem_out_s  response from data memory
- grant_id_o  out  $clog2(num_cores_p)  currently granted core
- busy_o  out  1  state != IDLE
- timeout_o  out  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0, grant_r=0, timer=0, timeout_o=0. All core_resp_o valid/yumi=0, mem_req_o.valid=0, mem_req_o.yumi=0.
- States: IDLE, REQ, RESP.
- IDLE:
  - Scan core_req_i[k].valid for k = rr_ptr, rr_ptr+1, ... mod num_cores_p. The first asserted k wins.
  - On a win: grant_r<=k, state<=REQ, timer<=0.
  - mem_req_o.valid=0 in IDLE, so arbitration adds exactly 1 cycle of latency.
- REQ:
  - mem_req_o = core_req_i[grant_r], except yumi. mem_addr_o = core_addr_i[grant_r].
  - mem_req_o.valid = core_req_i[grant_r].valid.
  - core_resp_o[grant_r].yumi = mem_resp_i.yumi. On mem_resp_i.yumi: state<=RESP.
  - If the granted core drops valid before yumi (protocol violation): state<=IDLE, rr_ptr unchanged.
- RESP:
  - mem_req_o.valid=0. wen, byte_not_word, write_data and mem_addr_o stay driven from grant_r.
  - core_resp_o[grant_r].valid = mem_resp_i.valid. mem_req_o.yumi = core_req_i[grant_r].yumi.
  - Completion = mem_resp_i.valid & core yumi. On completion: state<=IDLE, rr_ptr<=(grant_r+1) mod num_cores_p.
  - If mem_resp_i.valid is high without core yumi (core stalled): hold RESP.
- Simultaneous yumi and valid in REQ:
  - If mem_resp_i.yumi and mem_resp_i.valid are high in the same REQ cycle, forward both to the granted core.
  - If the core yumis that cycle, go directly to IDLE with rr_ptr advanced. Otherwise go to RESP.
- Response broadcast:
  - core_resp_o[*].read_data = mem_resp_i.read_data for every core.
  - valid/yumi are 0 for all non-granted cores in every state.
- Non-granted cores: requests are ignored (no yumi) and stay pending. Fairness: a continuously requesting core is granted within num_cores_p transactions.
- Timer:
  - Increments each cycle in REQ/RESP and saturates at timeout_p.
  - When timer == timeout_p, set timeout_o. timeout_o clears only on reset.
  - The transaction is not aborted; the state machine keeps waiting.
- grant_id_o = grant_r, including in IDLE (last grant). busy_o = (state != IDLE).
- Reset mid-transaction: returns to IDLE and drops the outstanding access. Data memory must be reset in the same cycle.

Test Plan:
- Single requester: core 2 valid=1, wen=0, addr=0x40 at cycle 0.
  - cycle 1: mem_req_o.valid=1, mem_addr_o=0x40, grant_id_o=2.
  - mem yumi at cycle 3: core_resp_o[2].yumi=1 at cycle 3.
  - mem valid with read_data=0xDEADBEEF at cycle 5, core yumi at cycle 5: busy_o=0 at cycle 6.
- Contention: cores 0, 1, 3 all request, rr_ptr=0 → grant order 0, 1, 3; rr_ptr=0 afterwards. Repeat from rr_ptr=2 → order 3, 0, 1.
- Same-cycle yumi+valid in REQ with core yumi → REQ to IDLE in one cycle, no RESP visited, rr_ptr advanced.
- Core stall in RESP: mem valid held high 4 cycles before core yumi → remains RESP, mem_req_o.yumi tracks core yumi, no other core granted meanwhile.
- Timeout with timeout_p=8: memory never yumis → timeout_o=1 exactly 8 cycles after entering REQ, state stays REQ. Later yumi/valid completes normally; timeout_o stays 1 until reset.
- Reset mid-RESP: reset=1 for 1 cycle → next cycle state=IDLE, busy_o=0, all valid/yumi outputs 0, rr_ptr=0, timeout_o=0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Shared data-memory request/response types and the arbiter bus interface.
// Cores, memory and the arbiter all see the same two-phase valid/yumi bundles.

package dmem_pkg;
    typedef struct packed {
        logic [31:0] write_data;
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic        yumi;
    } mem_in_s;

    typedef struct packed {
        logic [31:0] read_data;
        logic        valid;
        logic        yumi;
    } mem_out_s;
endpackage

interface dmem_arbiter_if #(
    parameter int num_cores_p  = 4,
    parameter int addr_width_p = 32
);
    import dmem_pkg::*;

    localparam int id_w = $clog2(num_cores_p);

    mem_in_s                 core_req_i  [num_cores_p];
    logic [addr_width_p-1:0] core_addr_i [num_cores_p];
    mem_out_s                core_resp_o [num_cores_p];
    mem_in_s                 mem_req_o;
    logic [addr_width_p-1:0] mem_addr_o;
    mem_out_s                mem_resp_i;
    logic [id_w-1:0]         grant_id_o;
    logic                    busy_o;
    logic                    timeout_o;

    modport slave (
        input  core_req_i, core_addr_i, mem_resp_i,
        output core_resp_o, mem_req_o, mem_addr_o,
        output grant_id_o, busy_o, timeout_o
    );

    modport master (
        output core_req_i, core_addr_i, mem_resp_i,
        input  core_resp_o, mem_req_o, mem_addr_o,
        input  grant_id_o, busy_o, timeout_o
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among several cores.
// One transaction in flight; the grant is held from request to response.

module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int num_cores_p  = 4,
    parameter int addr_width_p = 32,
    parameter int timeout_p    = 255
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);

    localparam int id_w  = $clog2(num_cores_p);
    localparam int tmr_w = $clog2(timeout_p + 1);
    localparam logic [tmr_w-1:0] tmr_max = tmr_w'(timeout_p);
    localparam logic [id_w-1:0]  id_last = id_w'(num_cores_p - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e           state;
    logic [id_w-1:0]  rr_ptr;
    logic [id_w-1:0]  grant_r;
    logic [tmr_w-1:0] timer;
    logic             timeout_r;

    mem_in_s          gsel;
    mem_out_s         resp_d [num_cores_p];
    logic             win;
    logic [id_w-1:0]  win_id;
    logic [id_w-1:0]  nxt_ptr;
    logic [tmr_w-1:0] timer_nx;
    logic             done;
    int               idx;

    assign gsel     = bus.core_req_i[grant_r];
    assign nxt_ptr  = (grant_r == id_last) ? '0 : grant_r + 1'b1;
    assign timer_nx = (timer == tmr_max) ? timer : timer + 1'b1;
    assign done     = bus.mem_resp_i.valid & gsel.yumi;

    assign bus.grant_id_o = grant_r;
    assign bus.busy_o     = (state != IDLE);
    assign bus.timeout_o  = timeout_r;
    assign bus.mem_addr_o = bus.core_addr_i[grant_r];

    // Round-robin scan: first valid requester starting at rr_ptr.
    always_comb begin
        win    = 1'b0;
        win_id = '0;
        idx    = 0;
        for (int i = 0; i < num_cores_p; i++) begin
            idx = (int'(rr_ptr) + i) % num_cores_p;
            if (!win && bus.core_req_i[idx].valid) begin
                win    = 1'b1;
                win_id = id_w'(idx);
            end
        end
    end

    // Route the granted core's handshakes to/from memory by phase.
    always_comb begin
        bus.mem_req_o       = gsel;
        bus.mem_req_o.valid = 1'b0;
        bus.mem_req_o.yumi  = 1'b0;
        for (int k = 0; k < num_cores_p; k++) begin
            resp_d[k].read_data = bus.mem_resp_i.read_data;
            resp_d[k].valid     = 1'b0;
            resp_d[k].yumi      = 1'b0;
        end
        unique case (state)
            REQ: begin
                bus.mem_req_o.valid   = gsel.valid;
                resp_d[grant_r].yumi  = bus.mem_resp_i.yumi;
                resp_d[grant_r].valid = bus.mem_resp_i.yumi
                                      & bus.mem_resp_i.valid;
                bus.mem_req_o.yumi    = bus.mem_resp_i.yumi
                                      & bus.mem_resp_i.valid
                                      & gsel.yumi;
            end
            RESP: begin
                resp_d[grant_r].valid = bus.mem_resp_i.valid;
                bus.mem_req_o.yumi    = gsel.yumi;
            end
            default: ;
        endcase
    end

    for (genvar g = 0; g < num_cores_p; g++) begin : g_resp
        assign bus.core_resp_o[g] = resp_d[g];
    end

    // Transaction FSM, round-robin pointer and sticky stall timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_r   <= '0;
            timer     <= '0;
            timeout_r <= 1'b0;
        end else begin
            if (state != IDLE) begin
                timer <= timer_nx;
                if (timer_nx == tmr_max) timeout_r <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (win) begin
                        grant_r <= win_id;
                        state   <= REQ;
                        timer   <= '0;
                    end
                end
                REQ: begin
                    if (!gsel.valid) begin
                        state <= IDLE;
                    end else if (bus.mem_resp_i.yumi) begin
                        if (done) begin
                            state  <= IDLE;
                            rr_ptr <= nxt_ptr;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (done) begin
                        state  <= IDLE;
                        rr_ptr <= nxt_ptr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations,
// then random traffic compared every cycle against a transaction model.

module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int T  = 8;

    logic clk;
    logic reset;
    int   nchk;
    int   nerr;

    dmem_arbiter_if #(.num_cores_p(N), .addr_width_p(AW)) bus();

    dmem_arbiter #(
        .num_cores_p (N),
        .addr_width_p(AW),
        .timeout_p   (T)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, got, exp, $time);
        end
    endtask

    // Model: who owns the port, whether memory has accepted the
    // request, how long the owner has held it, and the sticky flag.
    int      owner;
    int      last;
    int      ptr;
    int      elapsed;
    bit      accepted;
    bit      tflag;
    bit      mvalid;
    int      sk;
    mem_in_s mc;
    mem_out_s mm;

    initial mvalid = 0;

    always @(posedge clk) begin
        if (reset) begin
            owner = -1; last = 0; ptr = 0; elapsed = 0;
            accepted = 0; tflag = 0; mvalid = 1;
        end else if (mvalid) begin
            if (owner < 0) begin
                for (int i = 0; i < N; i++) begin
                    sk = (ptr + i) % N;
                    if (owner < 0 && bus.core_req_i[sk].valid) begin
                        owner = sk; last = sk;
                        accepted = 0; elapsed = 0;
                    end
                end
            end else begin
                mc = bus.core_req_i[owner];
                mm = bus.mem_resp_i;
                elapsed = (elapsed < T) ? elapsed + 1 : T;
                if (elapsed >= T) tflag = 1;
                if (!accepted && !mc.valid) begin
                    owner = -1;
                end else if (!accepted && !mm.yumi) begin
                    accepted = 0;
                end else if (mm.valid && mc.yumi) begin
                    ptr = (owner + 1) % N;
                    owner = -1;
                end else begin
                    accepted = 1;
                end
            end
        end
    end

    logic [N-1:0] ev, ey, av, ay;
    logic         emv, emy;
    mem_in_s      cc;

    // Per-cycle compare of all DUT outputs against the model.
    always @(negedge clk) begin
        if (mvalid) begin
            ev = '0; ey = '0; emv = 0; emy = 0;
            if (owner >= 0) begin
                cc = bus.core_req_i[owner];
                if (!accepted) begin
                    ey[owner] = bus.mem_resp_i.yumi;
                    ev[owner] = bus.mem_resp_i.yumi & bus.mem_resp_i.valid;
                    emv = cc.valid;
                    emy = bus.mem_resp_i.yumi & bus.mem_resp_i.valid
                        & cc.yumi;
                end else begin
                    ev[owner] = bus.mem_resp_i.valid;
                    emy = cc.yumi;
                end
                chk("m_addr", bus.mem_addr_o, bus.core_addr_i[owner]);
                chk("m_wen", bus.mem_req_o.wen, cc.wen);
                chk("m_bnw", bus.mem_req_o.byte_not_word, cc.byte_not_word);
                chk("m_wdata", bus.mem_req_o.write_data, cc.write_data);
            end
            for (int k = 0; k < N; k++) begin
                av[k] = bus.core_resp_o[k].valid;
                ay[k] = bus.core_resp_o[k].yumi;
                chk("m_rdata", bus.core_resp_o[k].read_data,
                    bus.mem_resp_i.read_data);
            end
            chk("m_busy", bus.busy_o, owner >= 0);
            chk("m_grant", bus.grant_id_o, last);
            chk("m_timeout", bus.timeout_o, tflag);
            chk("m_mvalid", bus.mem_req_o.valid, emv);
            chk("m_myumi", bus.mem_req_o.yumi, emy);
            chk("m_cvalid", av, ev);
            chk("m_cyumi", ay, ey);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clr();
        for (int k = 0; k < N; k++) begin
            bus.core_req_i[k]  = '0;
            bus.core_addr_i[k] = '0;
        end
        bus.mem_resp_i = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic run_txn(output int g);
        int n;
        n = 0;
        g = -1;
        while (!bus.busy_o && n < 20) begin
            step();
            n++;
        end
        chk("txn_start", bus.busy_o, 1'b1);
        if (bus.busy_o) begin
            g = int'(bus.grant_id_o);
            bus.mem_resp_i.yumi  = 1'b1;
            bus.mem_resp_i.valid = 1'b1;
            for (int k = 0; k < N; k++) bus.core_req_i[k].yumi = 1'b1;
            step();
            bus.mem_resp_i.yumi  = 1'b0;
            bus.mem_resp_i.valid = 1'b0;
            for (int k = 0; k < N; k++) bus.core_req_i[k].yumi = 1'b0;
            chk("txn_noresp", bus.busy_o, 1'b0);
        end
    endtask

    int g;
    int ord1 [4] = '{0, 1, 3, 0};
    int ord2 [3] = '{3, 0, 1};

    initial begin
        nchk = 0;
        nerr = 0;
        reset = 1'b0;
        clr();
        step();

        // Single requester, literal timeline.
        do_reset();
        chk("rst_busy", bus.busy_o, 1'b0);
        chk("rst_grant", bus.grant_id_o, 0);
        chk("rst_tmo", bus.timeout_o, 1'b0);
        bus.core_req_i[2].valid = 1'b1;
        bus.core_addr_i[2] = 32'h40;
        #3 chk("c0_mvalid", bus.mem_req_o.valid, 1'b0);
        step();
        #3;
        chk("c1_mvalid", bus.mem_req_o.valid, 1'b1);
        chk("c1_addr", bus.mem_addr_o, 32'h40);
        chk("c1_grant", bus.grant_id_o, 2);
        step();
        step();
        bus.mem_resp_i.yumi = 1'b1;
        #3 chk("c3_yumi", bus.core_resp_o[2].yumi, 1'b1);
        step();
        bus.mem_resp_i.yumi = 1'b0;
        bus.core_req_i[2].valid = 1'b0;
        step();
        bus.mem_resp_i.valid = 1'b1;
        bus.mem_resp_i.read_data = 32'hDEADBEEF;
        bus.core_req_i[2].yumi = 1'b1;
        #3;
        chk("c5_cvalid", bus.core_resp_o[2].valid, 1'b1);
        chk("c5_rdata", bus.core_resp_o[1].read_data, 32'hDEADBEEF);
        chk("c5_myumi", bus.mem_req_o.yumi, 1'b1);
        step();
        clr();
        chk("c6_busy", bus.busy_o, 1'b0);
        chk("c6_grant", bus.grant_id_o, 2);

        // Contention with same-cycle completion.
        do_reset();
        bus.core_req_i[0].valid = 1'b1;
        bus.core_req_i[1].valid = 1'b1;
        bus.core_req_i[3].valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_txn(g);
            chk("rr_order1", g, ord1[i]);
        end
        bus.core_req_i[0].valid = 1'b0;
        bus.core_req_i[3].valid = 1'b0;
        run_txn(g);
        chk("rr_core1", g, 1);
        bus.core_req_i[0].valid = 1'b1;
        bus.core_req_i[3].valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_txn(g);
            chk("rr_order2", g, ord2[i]);
        end
        clr();

        // Core stalls response for 4 cycles; others stay pending.
        do_reset();
        bus.core_req_i[0].valid = 1'b1;
        step();
        bus.mem_resp_i.yumi = 1'b1;
        step();
        bus.mem_resp_i.yumi = 1'b0;
        bus.core_req_i[0].valid = 1'b0;
        bus.core_req_i[1].valid = 1'b1;
        bus.mem_resp_i.valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #3;
            chk("st_busy", bus.busy_o, 1'b1);
            chk("st_grant", bus.grant_id_o, 0);
            chk("st_myumi", bus.mem_req_o.yumi, 1'b0);
            chk("st_other", bus.core_resp_o[1].yumi, 1'b0);
            step();
        end
        bus.core_req_i[0].yumi = 1'b1;
        #3 chk("st_myumi1", bus.mem_req_o.yumi, 1'b1);
        step();
        bus.core_req_i[0].yumi = 1'b0;
        bus.mem_resp_i.valid = 1'b0;
        chk("st_done", bus.busy_o, 1'b0);
        step();
        chk("st_next", bus.grant_id_o, 1);

        // Reset while core 1 waits in the response phase.
        bus.mem_resp_i.yumi = 1'b1;
        step();
        bus.mem_resp_i.yumi = 1'b0;
        bus.mem_resp_i.valid = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        clr();
        #3;
        chk("rm_busy", bus.busy_o, 1'b0);
        chk("rm_grant", bus.grant_id_o, 0);
        chk("rm_tmo", bus.timeout_o, 1'b0);
        chk("rm_cvalid", bus.core_resp_o[1].valid, 1'b0);
        for (int k = 0; k < N; k++) bus.core_req_i[k].valid = 1'b1;
        step();
        chk("rm_rr", bus.grant_id_o, 0);
        clr();

        // Memory never accepts: flag after T cycles in REQ.
        do_reset();
        bus.core_req_i[1].valid = 1'b1;
        for (int c = 1; c <= T; c++) step();
        chk("to_pre", bus.timeout_o, 1'b0);
        step();
        chk("to_set", bus.timeout_o, 1'b1);
        chk("to_busy", bus.busy_o, 1'b1);
        bus.mem_resp_i.yumi = 1'b1;
        bus.mem_resp_i.valid = 1'b1;
        bus.core_req_i[1].yumi = 1'b1;
        step();
        clr();
        chk("to_done", bus.busy_o, 1'b0);
        step();
        chk("to_sticky", bus.timeout_o, 1'b1);
        do_reset();
        chk("to_clear", bus.timeout_o, 1'b0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            step();
            reset = ($urandom_range(0, 199) == 0);
            for (int k = 0; k < N; k++) begin
                if (!bus.core_req_i[k].valid)
                    bus.core_req_i[k].valid = ($urandom_range(0, 2) == 0);
                else
                    bus.core_req_i[k].valid = ($urandom_range(0, 15) != 0);
                bus.core_req_i[k].yumi = ($urandom_range(0, 9) < 6);
                bus.core_req_i[k].wen = 1'($urandom);
                bus.core_req_i[k].byte_not_word = 1'($urandom);
                bus.core_req_i[k].write_data = $urandom;
                bus.core_addr_i[k] = $urandom;
            end
            bus.mem_resp_i.yumi = ($urandom_range(0, 9) < 4);
            bus.mem_resp_i.valid = ($urandom_range(0, 9) < 4);
            bus.mem_resp_i.read_data = $urandom;
        end
        step();
        reset = 1'b0;
        clr();
        step();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
